// File: rtl/ula_pkg.sv
// ula_pkg: shared opcode encoding and default datapath width for the ula_unit slice.
package ula_pkg;
   localparam int ULA_WIDTH = 8;
   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_NOT = 3'b100,
      OP_XOR = 3'b101,
      OP_MUL = 3'b110,
      OP_SLT = 3'b111
   } op_e;
endpackage

// File: rtl/ula_alu_comb.sv
// ula_alu_comb: combinational ALU computing the next result.
// Defining ULA_FLAGS_EN adds next zero/carry/negative/overflow outputs.
module ula_alu_comb
   import ula_pkg::*;
#(
   parameter int WIDTH = ULA_WIDTH
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       opcode,
`ifdef ULA_FLAGS_EN
   output logic             zero,
   output logic             carry,
   output logic             negative,
   output logic             overflow,
`endif
   output logic [WIDTH-1:0] res
);
   op_e w_op;
   assign w_op = op_e'(opcode);
   always_comb begin
      res = '0;
      case (w_op)
         OP_ADD: res = A + B;
         OP_SUB: res = A - B;
         OP_AND: res = A & B;
         OP_OR:  res = A | B;
         OP_NOT: res = ~A;
         OP_XOR: res = A ^ B;
         OP_MUL: res = WIDTH'(A * B);
         OP_SLT: res = {{(WIDTH-1){1'b0}}, A < B};
         default: res = '0;
      endcase
   end
`ifdef ULA_FLAGS_EN
   logic w_mul_hi;
   logic w_ovf_add;
   logic w_ovf_sub;
   // A truncated sum wraps below A exactly when a carry-out occurred.
   assign w_mul_hi  = (({{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B}) >> WIDTH) != '0;
   assign w_ovf_add = (A[WIDTH-1] == B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
   assign w_ovf_sub = (A[WIDTH-1] != B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
   assign zero      = (res == '0);
   assign negative  = res[WIDTH-1];
   assign carry     = (w_op == OP_ADD) ? (res < A) :
                      (w_op == OP_SUB) ? (A < B) :
                      (w_op == OP_MUL) ? w_mul_hi : 1'b0;
   assign overflow  = (w_op == OP_ADD) ? w_ovf_add :
                      (w_op == OP_SUB) ? w_ovf_sub : 1'b0;
`endif
endmodule

// File: rtl/ula_unit.sv
// ula_unit: registered ALU stage; S captures the ALU result every rising ck edge.
// Defining ULA_FLAGS_EN adds registered zero/carry/negative/overflow outputs.
module ula_unit
   import ula_pkg::*;
#(
   parameter int WIDTH = ULA_WIDTH
) (
   input  logic             ck,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       opcode,
`ifdef ULA_FLAGS_EN
   output logic             zero,
   output logic             carry,
   output logic             negative,
   output logic             overflow,
`endif
   output logic [WIDTH-1:0] S
);
   logic [WIDTH-1:0] w_res;
`ifdef ULA_FLAGS_EN
   logic w_zero, w_carry, w_neg, w_ovf;
`endif
   ula_alu_comb #(.WIDTH(WIDTH)) u_alu (
      .A        (A),
      .B        (B),
      .opcode   (opcode),
`ifdef ULA_FLAGS_EN
      .zero     (w_zero),
      .carry    (w_carry),
      .negative (w_neg),
      .overflow (w_ovf),
`endif
      .res      (w_res)
   );
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         S <= '0;
`ifdef ULA_FLAGS_EN
         {zero, carry, negative, overflow} <= '0;
`endif
      end else begin
         S <= w_res;
`ifdef ULA_FLAGS_EN
         {zero, carry, negative, overflow} <= {w_zero, w_carry, w_neg, w_ovf};
`endif
      end
   end
endmodule

// File: tb/tb_ula_unit.sv
// tb_ula_unit: directed self-checking bench for ula_unit (flag checks when ULA_FLAGS_EN is defined).
module tb_ula_unit;
   logic       ck = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] A = '0;
   logic [7:0] B = '0;
   logic [2:0] opcode = '0;
   logic [7:0] S;
   int total = 0;
   int bad = 0;
`ifdef ULA_FLAGS_EN
   logic zero, carry, negative, overflow;
`endif

   ula_unit #(.WIDTH(8)) dut (
      .ck       (ck),
      .rst      (rst),
      .A        (A),
      .B        (B),
      .opcode   (opcode),
`ifdef ULA_FLAGS_EN
      .zero     (zero),
      .carry    (carry),
      .negative (negative),
      .overflow (overflow),
`endif
      .S        (S)
   );

   always #5 ck = ~ck;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic [7:0] exp, input string tag);
      @(negedge ck);
      A = a;
      B = b;
      opcode = op;
      @(posedge ck);
      #1;
      check(tag, S, exp);
   endtask

   initial begin
      #1 rst = 1'b1;
      #2 check("reset_init", S, 8'h00);
`ifdef ULA_FLAGS_EN
      check("reset_flags", {4'h0, zero, carry, negative, overflow}, 8'h00);
`endif
      @(negedge ck);
      rst = 1'b0;
      A = 8'h01; B = 8'h01; opcode = 3'b000;
      #1 check("hold_after_release", S, 8'h00);
      @(posedge ck);
      #1 check("first_load_add", S, 8'h02);

      step(8'h0C, 8'h03, 3'b001, 8'h09, "sub_0c_03");
      step(8'hFF, 8'h01, 3'b000, 8'h00, "add_wrap");
`ifdef ULA_FLAGS_EN
      check("add_wrap_flags", {4'h0, zero, carry, negative, overflow}, 8'h0C);
`endif
      step(8'h00, 8'h01, 3'b001, 8'hFF, "sub_wrap");
`ifdef ULA_FLAGS_EN
      check("sub_wrap_flags", {4'h0, zero, carry, negative, overflow}, 8'h06);
`endif
      // Asynchronous reset in the middle of the low phase, S currently FF.
      @(negedge ck);
      #2 rst = 1'b1;
      #1 check("async_reset_clear", S, 8'h00);
      A = 8'h05; B = 8'h05; opcode = 3'b000;
      @(posedge ck);
      #1 check("reset_holds_over_edge", S, 8'h00);
      @(negedge ck);
      rst = 1'b0;
      A = 8'h01; B = 8'h01; opcode = 3'b000;
      #1 check("release_no_edge", S, 8'h00);
      @(posedge ck);
      #1 check("post_reset_add", S, 8'h02);

      step(8'hFF, 8'h00, 3'b010, 8'h00, "and_ff_00");
      step(8'h00, 8'h00, 3'b011, 8'h00, "or_00_00");
      step(8'h00, 8'h00, 3'b100, 8'hFF, "not_00");
      step(8'h03, 8'h02, 3'b101, 8'h01, "xor_03_02");
      step(8'h03, 8'h02, 3'b110, 8'h06, "mul_03_02");
      step(8'h10, 8'h10, 3'b110, 8'h00, "mul_wrap");
`ifdef ULA_FLAGS_EN
      check("mul_wrap_flags", {4'h0, zero, carry, negative, overflow}, 8'h0C);
`endif
      step(8'h02, 8'h03, 3'b111, 8'h01, "slt_lt");
      step(8'h03, 8'h03, 3'b111, 8'h00, "slt_eq");
      step(8'h03, 8'h02, 3'b111, 8'h00, "slt_gt");
      step(8'h5A, 8'h00, 3'b100, 8'hA5, "not_ignores_b0");
      step(8'h5A, 8'hFF, 3'b100, 8'hA5, "not_ignores_bff");

      // Opcode sweep with fixed operands: each S lags its opcode by one edge.
      step(8'h03, 8'h02, 3'b000, 8'h05, "lat_add");
      step(8'h03, 8'h02, 3'b001, 8'h01, "lat_sub");
      step(8'h03, 8'h02, 3'b010, 8'h02, "lat_and");
      step(8'h03, 8'h02, 3'b011, 8'h03, "lat_or");
      step(8'h03, 8'h02, 3'b100, 8'hFC, "lat_not");
      step(8'h03, 8'h02, 3'b101, 8'h01, "lat_xor");
      step(8'h03, 8'h02, 3'b110, 8'h06, "lat_mul");
      #1 A = 8'hF0; opcode = 3'b000;
      #2 check("between_edges_stable", S, 8'h06);
      step(8'h03, 8'h02, 3'b111, 8'h00, "lat_slt");

`ifdef ULA_FLAGS_EN
      step(8'h7F, 8'h01, 3'b000, 8'h80, "add_ovf");
      check("add_ovf_flags", {4'h0, zero, carry, negative, overflow}, 8'h03);
      step(8'h80, 8'h01, 3'b001, 8'h7F, "sub_ovf");
      check("sub_ovf_flags", {4'h0, zero, carry, negative, overflow}, 8'h01);
      step(8'hFF, 8'hFF, 3'b010, 8'hFF, "and_flags_val");
      check("and_flags", {4'h0, zero, carry, negative, overflow}, 8'h02);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ula_unit.md
Name: ula_unit

Overview:
- Registered 8-bit arithmetic/logic unit. It is selected by a 3-bit opcode.
- Operands A and B are combined combinationally, and the result is captured into output register S on each rising clock edge.
- Used as the datapath execution stage.
- No handshake: the block computes every cycle.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).

Ports:
- ck  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous active-high reset.
- A  input  WIDTH  operand A, unsigned unless noted.
- B  input  WIDTH  operand B, unsigned unless noted.
- opcode  input  3  operation select.
- S  output  WIDTH  registered result.

Behaviour:
- Reset: rst high clears S to 0 immediately, without waiting for ck. S holds 0 while rst is high. rst takes priority over any clock edge.
- Latency:
  - S at rising edge N reflects A, B and opcode sampled at edge N; S is visible one cycle after the inputs are applied.
  - Inputs may change every cycle; there is no pipeline stall.
- Opcode map (result truncated to WIDTH bits, wrap-around, no saturation):
  - 000 ADD: A + B, carry-out discarded (FF+01 -> 00).
  - 001 SUB: A - B, two's-complement wrap (00-01 -> FF).
  - 010 AND: A & B.
  - 011 OR: A | B.
  - 100 NOT: ~A; B is ignored.
  - 101 XOR: A ^ B.
  - 110 MUL: low WIDTH bits of A * B (10*10 -> 00).
  - 111 SLT: unsigned compare, 1 if A < B else 0, zero-extended. A == B gives 0.
- Opcode is fully decoded; there are no illegal values.
- Reset deassertion: S stays 0 until the first rising edge after rst falls, then loads normally.
- Reset asserted mid-operation discards the pending result.

Optional Feature:
- Macro: ULA_FLAGS_EN.
- When defined, four extra registered outputs are added: zero, carry, negative, overflow, each 1 bit.
  - All flags are cleared to 0 by rst and update on the same edge and with the same latency as S.
  - zero = (result == 0).
  - negative = result MSB.
  - carry:
    - ADD: carry-out.
    - SUB: borrow, i.e. 1 when A < B unsigned.
    - MUL: 1 when any upper product bit is nonzero.
    - All other opcodes: 0.
  - overflow:
    - ADD: signed overflow.
    - SUB: signed overflow.
    - All other opcodes: 0.
- When not defined, the flag ports and flag logic are absent; S behaviour is identical in both builds.

Decomposition:
- Package ula_pkg holds:
  - opcode typedef/enum: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_MUL, OP_SLT (values 000..111).
  - default WIDTH constant.
- One natural sub-module, ula_alu_comb:
  - purely combinational; computes the next result (and next flags when ULA_FLAGS_EN is defined) from A, B and opcode.
  - ula_unit wraps it with the async-reset output register.

Test Plan:
- Reset: drive rst=1 mid-run with S nonzero -> S=00 immediately without a clock edge. Release rst, then A=01, B=01, op=000 -> S=02 after the next rising edge.
- Arithmetic:
  - A=0C, B=03, op=001 -> S=09.
  - A=FF, B=01, op=000 -> S=00 (carry=1 when flags are built).
  - A=00, B=01, op=001 -> S=FF.
- Logic:
  - A=FF, B=00, op=010 -> S=00.
  - A=00, B=00, op=011 -> S=00.
  - A=00, B=00, op=100 -> S=FF.
  - A=03, B=02, op=101 -> S=01.
- MUL/SLT:
  - A=03, B=02, op=110 -> S=06.
  - A=10, B=10, op=110 -> S=00.
  - A=02, B=03, op=111 -> S=01.
  - A=03, B=03, op=111 -> S=00.
- Latency: change opcode every cycle with a fixed A=03, B=02 -> each S value lags its input by exactly one rising edge. Inputs changed between edges do not affect S.
- Flags build (ULA_FLAGS_EN): A=7F, B=01, op=000 -> S=80, overflow=1, negative=1, zero=0, carry=0.
